sum_averager: RTL
=================

SUM_AVERAGER -- requirements
Module: sum_averager

Interface
REQ-001 Parameter: LOG2_N, default 3, log2 of samples per averaging window (N = 2^LOG2_N, legal 1..6).
REQ-002 Parameter: IN_W, default 18, width of incoming sum samples.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous window abort; discards partial accumulation and any held result.
REQ-006 in_data  input  IN_W  unsigned sum sample from the upstream four-input adder.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 out_data  output  IN_W  unsigned window average.
REQ-010 out_valid  output  1  out_data holds a completed average.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 win_count  output  8  number of averages handed off, modulo 256.

Function
REQ-013 Two states: ACC (collecting samples) and HOLD (result waiting for handoff).
REQ-014 Sample accepted when in_valid && in_ready at a rising edge; in_ready = 1 in ACC, 0 in HOLD.
REQ-015 Accumulator width IN_W+LOG2_N (21 bits at defaults); shall never overflow.
REQ-016 Sample counter LOG2_N bits, increments per accepted sample.
REQ-017 On acceptance of the Nth sample: out_data <= (acc + in_data) >> LOG2_N, out_valid <= 1, acc <= 0, counter <= 0, state -> HOLD; out_valid rises one cycle after the Nth acceptance.
REQ-018 In HOLD: out_data and out_valid stable until out_valid && out_ready at a rising edge; then out_valid <= 0, win_count increments, state -> ACC.
REQ-019 No new sample may be accepted in the handoff cycle; first new sample is accepted the cycle after.
REQ-020 win_count wraps 255 -> 0.
REQ-021 clear = 1 at a rising edge: acc <= 0, counter <= 0, out_valid <= 0, state -> ACC; win_count unchanged; out_data retains its last value.
REQ-022 clear wins over a simultaneous sample acceptance (sample dropped) and over a simultaneous handoff (win_count not incremented).
REQ-023 in_data ignored when in_valid = 0 or in_ready = 0.

Reset
REQ-024 rst = 1 asynchronously forces: state ACC, acc 0, counter 0, out_data 0, out_valid 0, win_count 0.
REQ-025 in_ready reads 1 during and immediately after reset.
REQ-026 Reset mid-window or mid-HOLD discards all partial and held data; no result is emitted for that window.

Configuration
REQ-027 Macro AVG_ROUND_EN defined: out_data = (sum + 2^(LOG2_N-1)) >> LOG2_N, round-half-up; the rounding add shall not overflow.
REQ-028 Macro AVG_ROUND_EN undefined: out_data = sum >> LOG2_N, truncation; no rounding adder is present.

Verification
REQ-029 Reset, then 8 back-to-back samples of 4444 with out_ready = 1 -> out_valid high for 1 cycle, out_data 4444, win_count 1.
REQ-030 Samples 1..8 -> out_data 4 without AVG_ROUND_EN, 5 with AVG_ROUND_EN.
REQ-031 8 samples of 262143, out_ready held 0 for 3 cycles -> out_data 262143 stable, out_valid high, in_ready 0 throughout; handoff on out_ready = 1, then in_ready 1.
REQ-032 3 samples of 9999, clear pulse, then 8 samples of 100 -> single result 100, win_count 1.
REQ-033 rst asserted while in HOLD -> out_valid and out_data 0 immediately, win_count 0; next 8 samples of 13332 -> out_data 13332.
REQ-034 256 windows of 22220 handed off -> win_count wraps to 0, every out_data 22220.

Source files
------------

// File: rtl/sum_averager.sv
// rtl/sum_averager.sv - windowed averager of upstream sum samples (optional rounding via AVG_ROUND_EN)
module sum_averager #(
  parameter int LOG2_N = 3,
  parameter int IN_W   = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [IN_W-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      win_count
);

  // N samples of at most 2^IN_W-1 always fit in IN_W+LOG2_N bits
  localparam int ACC_W = IN_W + LOG2_N;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [LOG2_N-1:0] cnt;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  avg_src;
  logic              last_sample;

  assign in_ready    = (state == ST_ACC);
  assign sum         = acc + ACC_W'(in_data);
  assign last_sample = &cnt;

`ifdef AVG_ROUND_EN
  // Adding N/2 cannot overflow: the largest window sum is N*2^IN_W - N,
  // so the rounded value stays below 2^ACC_W.
  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_N - 1);
  assign avg_src = sum + HALF;
`else
  assign avg_src = sum;
`endif

  // Window accumulation, result hold/handoff and handoff counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      win_count <= '0;
    end else if (clear) begin
      // Abort beats both a sample and a handoff in the same cycle; the last
      // published value stays on out_data.
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (state == ST_ACC) begin
      if (in_valid) begin
        if (last_sample) begin
          out_data  <= avg_src[ACC_W-1:LOG2_N];
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          state     <= ST_HOLD;
        end else begin
          acc <= sum;
          cnt <= cnt + LOG2_N'(1);
        end
      end
    end else begin
      // in_ready is low while holding, so no sample is taken in the handoff cycle
      if (out_ready) begin
        out_valid <= 1'b0;
        win_count <= win_count + 8'd1;
        state     <= ST_ACC;
      end
    end
  end

endmodule
